// File: rtl/axis_video_pkg.sv
// Shared types and constants for the AXI4-Stream video frame guard.
package axis_video_pkg;

   typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

   localparam int unsigned ERR_EOL_EARLY = 0;
   localparam int unsigned ERR_EOL_LATE  = 1;
   localparam int unsigned ERR_SOF_MID   = 2;
   localparam int unsigned ERR_BITS      = 3;

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI4-Stream output register; upstream ready is combinational pass-through.
module axis_reg_slice #(
   parameter int unsigned Width = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   input  logic [Width-1:0] in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [Width-1:0] out_data_o,
   input  logic             out_ready_i
);

   logic             valid_q;
   logic [Width-1:0] data_q;

   assign in_ready_o  = ~valid_q | out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (in_ready_o) begin
         valid_q <= in_valid_i;
         if (in_valid_i) begin
            data_q <= in_data_i;
         end
      end
   end

endmodule

// File: rtl/axis_video_frame_guard.sv
// AXIS video frame sanitiser: SOF alignment, geometry check, tlast/tuser regeneration.
// Optional statistics outputs are enabled by defining AXIS_FRAME_STATS_EN.
module axis_video_frame_guard
   import axis_video_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned XW        = 12,
   parameter int unsigned YW        = 12
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   input  logic [XW-1:0]        cfg_width,
   input  logic [YW-1:0]        cfg_height,
   input  logic                 err_clr,
   output logic [ERR_BITS-1:0]  err_status,
   output logic                 frame_done
`ifdef AXIS_FRAME_STATS_EN
   ,
   output logic [31:0]          frame_count,
   output logic [31:0]          drop_count,
   output logic [XW-1:0]        meas_width
`endif
);

   state_e                state_q, state_d;
   logic [XW-1:0]         x_q, x_d, w_q, w_d;
   logic [YW-1:0]         y_q, y_d, h_q, h_d;
   logic [ERR_BITS-1:0]   err_q, err_d, err_set;
   logic                  done_q, done_d;
   logic                  accept, fwd, o_user, o_last, x_last, y_last;
   logic [DATA_BITS+1:0]  slice_out;

   assign accept = s_axis_tvalid & s_axis_tready;
   assign x_last = (x_q == w_q - XW'(1));
   assign y_last = (y_q == h_q - YW'(1));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      err_set = '0;
      done_d  = 1'b0;
      fwd     = 1'b0;
      o_user  = 1'b0;
      o_last  = 1'b0;
      if (accept) begin
         if (s_axis_tuser) begin
            // An SOF beat is pixel (0,0) of a new frame, checked against the fresh geometry.
            if (state_q == StPass && (x_q != '0 || y_q != '0)) begin
               err_set[ERR_SOF_MID] = 1'b1;
            end
            w_d = cfg_width;
            h_d = cfg_height;
            x_d = '0;
            y_d = '0;
            if (cfg_width == '0 || cfg_height == '0) begin
               state_d = StIdle;
            end else begin
               fwd     = 1'b1;
               o_user  = 1'b1;
               state_d = StPass;
               if (cfg_width == XW'(1)) begin
                  o_last = 1'b1;
                  if (cfg_height == YW'(1)) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     y_d = YW'(1);
                  end
               end else begin
                  x_d = XW'(1);
               end
            end
         end else if (state_q == StPass) begin
            fwd    = 1'b1;
            o_user = (x_q == '0) && (y_q == '0);
            o_last = s_axis_tlast | x_last;
            if (s_axis_tlast && !x_last) begin
               err_set[ERR_EOL_EARLY] = 1'b1;
               state_d                = StDrop;
            end else if (x_last && !s_axis_tlast) begin
               err_set[ERR_EOL_LATE] = 1'b1;
               state_d               = StDrop;
            end else if (x_last) begin
               x_d = '0;
               y_d = y_q + YW'(1);
               if (y_last) begin
                  y_d     = '0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end else begin
               x_d = x_q + XW'(1);
            end
         end
      end
      // A new error in the same cycle as err_clr survives the clear.
      err_d = (err_clr ? '0 : err_q) | err_set;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   axis_reg_slice #(
      .Width(DATA_BITS + 2)
   ) u_slice (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .in_valid_i  (fwd),
      .in_data_i   ({o_user, o_last, s_axis_tdata}),
      .in_ready_o  (s_axis_tready),
      .out_valid_o (m_axis_tvalid),
      .out_data_o  (slice_out),
      .out_ready_i (m_axis_tready)
   );

   assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = slice_out;
   assign err_status = err_q;
   assign frame_done = done_q;

`ifdef AXIS_FRAME_STATS_EN
   logic [31:0]   frame_cnt_q, drop_cnt_q;
   logic [XW-1:0] meas_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         meas_q      <= '0;
      end else begin
         if (done_d) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
         end
         if (accept && !fwd && drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
         end
         if (accept && s_axis_tlast) begin
            meas_q <= s_axis_tuser ? XW'(1) : x_q + XW'(1);
         end
      end
   end

   assign frame_count = frame_cnt_q;
   assign drop_count  = drop_cnt_q;
   assign meas_width  = meas_q;
`endif

endmodule

// File: tb/tb_axis_video_frame_guard.sv
// Directed self-checking bench for axis_video_frame_guard (default build, stats disabled).
module tb_axis_video_frame_guard;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [11:0] cfg_width = 12'd4;
   logic [11:0] cfg_height = 12'd2;
   logic        err_clr = 1'b0;
   logic [2:0]  err_status;
   logic        frame_done;

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [9:0]  outq[$];
   logic [9:0]  expq[$];
   logic        bp_en = 1'b0;
   logic        bp_rdy = 1'b1;
   logic        rdy_man = 1'b1;
   logic        prev_stall = 1'b0;
   logic [9:0]  prev_beat = '0;

   assign m_axis_tready = bp_en ? bp_rdy : rdy_man;

   axis_video_frame_guard dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .cfg_width     (cfg_width),
      .cfg_height    (cfg_height),
      .err_clr       (err_clr),
      .err_status    (err_status),
      .frame_done    (frame_done)
   );

   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] beat(input logic u, input logic l, input logic [7:0] d);
      return {u, l, d};
   endfunction

   // Random downstream ready while back-pressure is enabled.
   always @(posedge aclk) begin
      #2;
      bp_rdy = ($urandom_range(0, 3) != 0);
   end

   // Collect handshaken output beats; check stalled outputs are held.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (bp_en && prev_stall) begin
            check("stall_hold", {21'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                  {21'd0, 1'b1, prev_beat});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
         end
         if (frame_done) begin
            done_cnt++;
         end
         prev_stall = m_axis_tvalid & ~m_axis_tready;
         prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send(input logic [7:0] d, input logic u, input logic l);
      bit got = 0;
      if (bp_en && $urandom_range(0, 2) == 0) begin
         s_axis_tvalid = 1'b0;
         @(posedge aclk);
         #1;
      end
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk);
         if (s_axis_tready) begin
            got = 1;
            break;
         end
      end
      if (!got) check("send_tready", {31'd0, s_axis_tready}, 32'd1);
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base, input int w, input int h);
      for (int i = 0; i < w * h; i++) send(base + 8'(i), i == 0, (i % w) == w - 1);
   endtask

   task automatic add_frame(input logic [7:0] base, input int w, input int h);
      for (int i = 0; i < w * h; i++) expq.push_back(beat(i == 0, (i % w) == w - 1, base + 8'(i)));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic compare_queue(input string tag);
      check({tag, "_len"}, outq.size(), expq.size());
      foreach (expq[i]) begin
         check($sformatf("%s_beat%0d", tag, i),
               (i < outq.size()) ? {22'd0, outq[i]} : 32'hDEAD, {22'd0, expq[i]});
      end
      outq.delete();
      expq.delete();
   endtask

   initial begin
      // Reset state
      idle(3);
      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
      check("rst_tlast_tuser", {30'd0, m_axis_tlast, m_axis_tuser}, 32'd0);
      check("rst_err", {29'd0, err_status}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
      aresetn = 1'b1;
      idle(2);

      // Junk before SOF, then two clean 4x2 frames
      send(8'hA0, 0, 0);
      send(8'hA1, 0, 1);
      send(8'hA2, 0, 0);
      send_frame(8'h10, 4, 2);
      send_frame(8'h20, 4, 2);
      idle(4);
      check("clean_b0", {22'd0, outq[0]}, {22'd0, 10'h210});
      check("clean_b3", {22'd0, outq[3]}, {22'd0, 10'h113});
      check("clean_b7", {22'd0, outq[7]}, {22'd0, 10'h117});
      add_frame(8'h10, 4, 2);
      add_frame(8'h20, 4, 2);
      compare_queue("clean");
      check("clean_done", done_cnt, 2);
      check("clean_err", {29'd0, err_status}, 32'd0);

      // Early EOL on the third pixel
      done_cnt = 0;
      send(8'h30, 1, 0);
      send(8'h31, 0, 0);
      send(8'h32, 0, 1);
      send(8'h33, 0, 0);
      send(8'h34, 0, 1);
      idle(4);
      expq.push_back(10'h230);
      expq.push_back(10'h031);
      expq.push_back(10'h132);
      compare_queue("early");
      check("early_err", {29'd0, err_status}, 32'd1);
      check("early_nodone", done_cnt, 0);
      send_frame(8'h40, 4, 2);
      idle(4);
      add_frame(8'h40, 4, 2);
      compare_queue("early_resync");
      check("early_resync_done", done_cnt, 1);
      check("early_sticky", {29'd0, err_status}, 32'd1);

      // Late EOL; err_clr coincides with the new error, which must survive
      done_cnt = 0;
      send(8'h50, 1, 0);
      send(8'h51, 0, 0);
      send(8'h52, 0, 0);
      err_clr = 1'b1;
      send(8'h53, 0, 0);
      err_clr = 1'b0;
      send(8'h54, 0, 0);
      send(8'h55, 0, 0);
      idle(4);
      expq.push_back(10'h250);
      expq.push_back(10'h051);
      expq.push_back(10'h052);
      expq.push_back(10'h153);
      compare_queue("late");
      check("late_err", {29'd0, err_status}, 32'd2);
      check("late_nodone", done_cnt, 0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("err_clr", {29'd0, err_status}, 32'd0);

      // Zero width: SOF is not accepted as a frame start
      cfg_width = 12'd0;
      send(8'h80, 1, 0);
      send(8'h81, 0, 1);
      cfg_width = 12'd4;
      send(8'h82, 0, 0);
      idle(4);
      compare_queue("zero_w");
      check("zero_w_err", {29'd0, err_status}, 32'd0);

      // SOF mid-frame at x=2,y=1; cfg change after SOF is ignored
      done_cnt = 0;
      for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), i == 0, i == 3);
      send(8'h70, 1, 0);
      cfg_width = 12'd2;
      for (int i = 1; i < 8; i++) send(8'h70 + 8'(i), 0, (i % 4) == 3);
      cfg_width = 12'd4;
      idle(4);
      for (int i = 0; i < 6; i++) expq.push_back(beat(i == 0, i == 3, 8'h60 + 8'(i)));
      add_frame(8'h70, 4, 2);
      compare_queue("sofmid");
      check("sofmid_err", {29'd0, err_status}, 32'd4);
      check("sofmid_done", done_cnt, 1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;

      // Random back-pressure on a clean 8x4 frame
      done_cnt   = 0;
      cfg_width  = 12'd8;
      cfg_height = 12'd4;
      bp_en      = 1'b1;
      send_frame(8'h00, 8, 4);
      for (int i = 0; i < 1000 && outq.size() < 32; i++) @(posedge aclk);
      idle(4);
      bp_en = 1'b0;
      add_frame(8'h00, 8, 4);
      compare_queue("bp");
      check("bp_done", done_cnt, 1);
      check("bp_err", {29'd0, err_status}, 32'd0);

      // Reset mid-frame with a beat stalled in the output register
      cfg_width  = 12'd4;
      cfg_height = 12'd2;
      send(8'h90, 1, 0);
      send(8'h91, 0, 1);
      idle(3);
      expq.push_back(10'h290);
      expq.push_back(10'h191);
      compare_queue("pre_rst");
      rdy_man = 1'b0;
      send(8'h92, 1, 0);
      check("stalled_valid", {31'd0, m_axis_tvalid}, 32'd1);
      check("stalled_data", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, 10'h292});
      check("pre_rst_err", {29'd0, err_status}, 32'd1);
      #2;
      aresetn = 1'b0;
      #1;
      check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("mid_rst_data", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 32'd0);
      check("mid_rst_err", {29'd0, err_status}, 32'd0);
      check("mid_rst_done", {31'd0, frame_done}, 32'd0);
      idle(2);
      aresetn = 1'b1;
      rdy_man = 1'b1;
      done_cnt = 0;
      outq.delete();
      send(8'h93, 0, 0);
      send_frame(8'hB0, 4, 2);
      idle(4);
      add_frame(8'hB0, 4, 2);
      compare_queue("post_rst");
      check("post_rst_done", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
